regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Read-side companion of the datapath register file. On a start pulse it walks register
//  addresses FIRST_REG..LAST_REG on read port A, captures bus_a and streams each word out
//  over a valid/ready interface. Used for debug dump and state checkpointing.
//  Sits beside the control unit. It only drives addr_a while busy, so the mux to addr_a
//  belongs to the owner of that port.
// PARAMETERS
//  DATA_W     16   register/data word width
//  ADDR_W     4    register address width (16 registers)
//  FIRST_REG  0    first register address dumped
//  LAST_REG   15   last register address dumped; FIRST_REG <= LAST_REG < 2**ADDR_W
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high; clears all state immediately
//  start      in   1       one-cycle request to begin a dump; ignored while busy
//  abort      in   1       synchronous cancel of a dump in progress
//  addr_a     out  ADDR_W  read address to register file port A
//  bus_a      in   DATA_W  register file port A read data (combinational from addr_a)
//  out_data   out  DATA_W  streamed word
//  out_index  out  ADDR_W  register address of out_data
//  out_valid  out  1       out_data/out_index/out_last valid
//  out_ready  in   1       sink accepts word when out_valid & out_ready at a rising edge
//  out_last   out  1       marks final word of the dump
//  busy       out  1       high from the cycle after start until completion or abort
//  done       out  1       one-cycle pulse after the final word is accepted
// BEHAVIOUR
//  Reset values: addr_a=FIRST_REG, out_data=0, out_index=0, out_valid=0, out_last=0,
//   busy=0, done=0, state=IDLE.
//  FSM: IDLE -> FETCH -> SEND -> (FETCH | CSUM | IDLE).
//  - IDLE: busy=0. When start=1: idx<=FIRST_REG, go to FETCH.
//  - FETCH: addr_a=idx. At the edge: out_data<=bus_a, out_index<=idx,
//    out_valid<=1, out_last<=(idx==LAST_REG && !CSUM), go to SEND.
//  - SEND: out_* held stable while out_valid & !out_ready.
//    On accept with idx!=LAST_REG: out_valid<=0, idx<=idx+1, go to FETCH.
//    On accept with idx==LAST_REG: go to CSUM when enabled; otherwise
//    IDLE with done<=1.
//  Throughput: 1 word per 2 cycles minimum. First out_valid appears 2 cycles after start.
//  Index compare happens before increment, so LAST_REG=2**ADDR_W-1 never wraps into a
//   second pass.
//  abort=1 in any non-IDLE state: next state IDLE, out_valid<=0, out_last<=0, no done.
//   abort wins over a simultaneous out_ready, and that word counts as not transferred.
//  start during busy: ignored. start and abort together in IDLE: start is taken.
//  addr_a holds idx in every state; in IDLE it holds its last value.
//  Reset mid-dump: all outputs return to reset values asynchronously; no done pulse.
// CONFIGURATION
//  REGDUMP_CHECKSUM_EN defined:
//  - A DATA_W XOR accumulator clears on start and XORs in each word captured in FETCH.
//  - After the last register is accepted, the CSUM state presents out_data=accumulator,
//    out_index=LAST_REG and out_last=1.
//  - The dump completes (done pulse) when this word is accepted.
//  - Abort is honoured in CSUM.
//  Undefined: no accumulator, no CSUM state; out_last rides on register LAST_REG.
// STRUCTURE
//  Shared package marc_datapath_pkg: DATA_W/ADDR_W defaults, FSM state encodings
//   (IDLE, FETCH, SEND, CSUM).
//  One natural sub-module: regdump_xor_accum (clear/enable XOR accumulator), instantiated
//   only under REGDUMP_CHECKSUM_EN.
// TESTING
//  1 Load all 16 regs with 16'hFFDD, out_ready=1, pulse start:
//    16 words of 16'hFFDD with indices 0..15; out_last only on index 15; done pulses once.
//    Without CSUM the dump takes 32 cycles from the first FETCH.
//  2 Regs loaded with reg[i]=16'h0100+i, out_ready toggling 1/0 every cycle:
//    data stays stable while stalled, no word is duplicated or dropped, order is 0..15.
//  3 Abort asserted with out_ready=1 during SEND of index 5:
//    index 5 is not transferred; out_valid=0 next cycle; busy falls; done stays 0.
//  4 Reset asserted mid-dump at index 9 between clock edges:
//    outputs drop immediately to reset values; a new start dumps again from index 0.
//  5 REGDUMP_CHECKSUM_EN, reg[i]=16'h0100+i: a 17th word of 16'h0000 arrives with
//    out_last=1 (word 15 has out_last=0). Dump with all regs 16'hFFDD yields 16'h0000;
//    reg0=16'h1234, rest 0 yields 16'h1234.
//  6 FIRST_REG=3, LAST_REG=3: exactly one word, index 3, carrying out_last; start
//    re-pulsed while busy is ignored.

Source files
------------

// File: rtl/marc_datapath_pkg.sv
// Shared datapath definitions: default word/address widths and the dump-reader FSM encodings.
package marc_datapath_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    typedef logic [1:0] dump_state_t;

    localparam dump_state_t ST_IDLE  = 2'd0;
    localparam dump_state_t ST_FETCH = 2'd1;
    localparam dump_state_t ST_SEND  = 2'd2;
    localparam dump_state_t ST_CSUM  = 2'd3;

endpackage

// File: rtl/regdump_xor_accum.sv
// Running XOR of dumped words; clear has priority over enable.
module regdump_xor_accum
    import marc_datapath_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks register-file port A from FIRST_REG to LAST_REG and streams each word over valid/ready.
// Optional trailing XOR checksum word is enabled by defining REGDUMP_CHECKSUM_EN.
module regfile_dump_reader
    import marc_datapath_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              last_on_reg;

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    regdump_xor_accum #(
        .DATA_W(DATA_W)
    ) u_accum (
        .clk  (clk),
        .reset(reset),
        .clr  ((state_q == ST_IDLE) && start),
        .en   ((state_q == ST_FETCH) && !abort),
        .din  (bus_a),
        .acc  (csum)
    );

    // The checksum word carries out_last instead of the final register.
    assign last_on_reg = 1'b0;
`else
    assign last_on_reg = (idx_q == LAST_A);
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = FIRST_A;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_data_d  = bus_a;
                    out_index_d = idx_q;
                    out_valid_d = 1'b1;
                    out_last_d  = last_on_reg;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_IDLE;
                end else if (out_ready) begin
                    // Compare before increment so a full-range dump cannot wrap.
                    if (idx_q != LAST_A) begin
                        out_valid_d = 1'b0;
                        idx_d       = idx_q + ADDR_W'(1);
                        state_d     = ST_FETCH;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        out_data_d  = csum;
                        out_index_d = LAST_A;
                        out_last_d  = 1'b1;
                        state_d     = ST_CSUM;
`else
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
`endif
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
`endif
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= FIRST_A;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign addr_a    = idx_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full-range instance plus a single-register (3..3) instance.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int NW    = 17;
    localparam int NBUSY = 33;
    localparam int NW3   = 2;
`else
    localparam int NW    = 16;
    localparam int NBUSY = 32;
    localparam int NW3   = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] regs [16];

    logic        start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic [3:0]  addr_a, out_index;
    logic [15:0] bus_a, out_data;
    logic        out_valid, out_last, busy, done;

    logic        start3 = 1'b0, abort3 = 1'b0, ready3 = 1'b1;
    logic [3:0]  addr3, out_index3;
    logic [15:0] bus3, out_data3;
    logic        out_valid3, out_last3, busy3, done3;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [15:0] cap_data [32];
    logic [3:0]  cap_idx  [32];
    logic        cap_last [32];
    int n_words, busy_cyc, first_valid, stall_bad, done_cyc, last_cnt;
    bit timed_out;

    always #5 clk = ~clk;

    assign bus_a = regs[addr_a];
    assign bus3  = regs[addr3];

    regfile_dump_reader #(.DATA_W(16), .ADDR_W(4), .FIRST_REG(0), .LAST_REG(15)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .addr_a(addr_a), .bus_a(bus_a),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    regfile_dump_reader #(.DATA_W(16), .ADDR_W(4), .FIRST_REG(3), .LAST_REG(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort3), .addr_a(addr3), .bus_a(bus3),
        .out_data(out_data3), .out_index(out_index3), .out_valid(out_valid3), .out_ready(ready3),
        .out_last(out_last3), .busy(busy3), .done(done3)
    );

    // Pulses start and records every accepted word; entered and left at a falling edge.
    task automatic run_dump(input bit toggle);
        logic [15:0] pd;
        logic [3:0]  pi;
        logic        pl;
        bit          prev_stall;
        n_words = 0; busy_cyc = 0; first_valid = -1; stall_bad = 0; done_cyc = -1;
        last_cnt = 0; timed_out = 1'b1; prev_stall = 1'b0; pd = '0; pi = '0; pl = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (toggle) out_ready = (cyc % 2 == 1);
            if (prev_stall && (out_data !== pd || out_index !== pi || out_last !== pl || out_valid !== 1'b1))
                stall_bad++;
            if (busy) busy_cyc++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cyc = cyc;
                timed_out = 1'b0;
                @(negedge clk);
                break;
            end
            if (out_valid && out_ready && n_words < 32) begin
                cap_data[n_words] = out_data;
                cap_idx[n_words]  = out_index;
                cap_last[n_words] = out_last;
                if (out_last) last_cnt++;
                n_words++;
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; pi = out_index; pl = out_last;
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++; if (addr_a !== 4'd0) begin err_cnt++; $display("FAIL reset_addr_a: got %0d want 0", addr_a); end
        vec_cnt++; if (out_data !== 16'h0 || out_index !== 4'd0) begin err_cnt++; $display("FAIL reset_out: data %h idx %0d want 0/0", out_data, out_index); end
        vec_cnt++; if ({out_valid, out_last, busy, done} !== 4'b0) begin err_cnt++; $display("FAIL reset_flags: v/l/b/d %b want 0000", {out_valid, out_last, busy, done}); end
        vec_cnt++; if (addr3 !== 4'd3) begin err_cnt++; $display("FAIL reset_addr3: got %0d want 3", addr3); end
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < 16; i++) regs[i] = 16'hFFDD;
        run_dump(1'b0);
        vec_cnt++; if (timed_out) begin err_cnt++; $display("FAIL full_timeout: done not seen"); end
        vec_cnt++; if (n_words !== NW) begin err_cnt++; $display("FAIL full_count: got %0d want %0d", n_words, NW); end
        for (int i = 0; i < 16; i++) begin
            vec_cnt++;
            if (cap_data[i] !== 16'hFFDD || cap_idx[i] !== 4'(i)) begin
                err_cnt++; $display("FAIL full_word%0d: got %h@%0d want ffdd@%0d", i, cap_data[i], cap_idx[i], i);
            end
        end
        vec_cnt++; if (last_cnt !== 1 || cap_last[NW-1] !== 1'b1) begin err_cnt++; $display("FAIL full_last: count %0d final %b want 1/1", last_cnt, cap_last[NW-1]); end
        vec_cnt++; if (busy_cyc !== NBUSY) begin err_cnt++; $display("FAIL full_busy: got %0d want %0d", busy_cyc, NBUSY); end
        vec_cnt++; if (first_valid !== 2) begin err_cnt++; $display("FAIL full_latency: got %0d want 2", first_valid); end
        vec_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL full_done_pulse: done %b busy %b want 0/0", done, busy); end
        $display("test_full_dump: %0d words, busy %0d cycles", n_words, busy_cyc);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) regs[i] = 16'h0100 + 16'(i);
        run_dump(1'b1);
        vec_cnt++; if (n_words !== NW || timed_out) begin err_cnt++; $display("FAIL bp_count: got %0d timeout %b want %0d", n_words, timed_out, NW); end
        for (int i = 0; i < 16; i++) begin
            vec_cnt++;
            if (cap_data[i] !== 16'h0100 + 16'(i) || cap_idx[i] !== 4'(i)) begin
                err_cnt++; $display("FAIL bp_word%0d: got %h@%0d want %h@%0d", i, cap_data[i], cap_idx[i], 16'h0100 + 16'(i), i);
            end
        end
        vec_cnt++; if (stall_bad !== 0) begin err_cnt++; $display("FAIL bp_stable: %0d changes while stalled, want 0", stall_bad); end
        $display("test_backpressure: %0d words", n_words);
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        int acc = 0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && out_index == 4'd5) begin found = 1'b1; break; end
            if (out_valid && out_ready) acc++;
            @(negedge clk);
        end
        vec_cnt++; if (!found) begin err_cnt++; $display("FAIL abort_reach5: index 5 never presented"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vec_cnt++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin err_cnt++; $display("FAIL abort_valid: v %b l %b want 0/0", out_valid, out_last); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy: got %b want 0", busy); end
        vec_cnt++; if (acc !== 5) begin err_cnt++; $display("FAIL abort_transferred: got %0d want 5", acc); end
        for (int c = 0; c < 4; c++) begin
            vec_cnt++; if (done !== 1'b0 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_quiet%0d: done %b valid %b want 0/0", c, done, out_valid); end
            @(negedge clk);
        end
        $display("test_abort: %0d words before abort", acc);
    endtask

    task automatic test_reset_mid_dump();
        bit found = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 16'hA000 + 16'(i);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && out_index == 4'd9) begin found = 1'b1; break; end
            @(negedge clk);
        end
        vec_cnt++; if (!found) begin err_cnt++; $display("FAIL rst_reach9: index 9 never presented"); end
        #2 reset = 1'b1;
        #1;
        vec_cnt++; if ({out_valid, out_last, busy, done} !== 4'b0) begin err_cnt++; $display("FAIL rst_async_flags: v/l/b/d %b want 0000", {out_valid, out_last, busy, done}); end
        vec_cnt++; if (out_data !== 16'h0 || out_index !== 4'd0 || addr_a !== 4'd0) begin err_cnt++; $display("FAIL rst_async_out: data %h idx %0d addr %0d want 0/0/0", out_data, out_index, addr_a); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_dump(1'b0);
        vec_cnt++; if (n_words !== NW || cap_idx[0] !== 4'd0 || cap_data[0] !== 16'hA000) begin
            err_cnt++; $display("FAIL rst_redump: %0d words first %h@%0d want %0d words a000@0", n_words, cap_data[0], cap_idx[0], NW);
        end
        $display("test_reset_mid_dump: redump %0d words", n_words);
    endtask

`ifdef REGDUMP_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < 16; i++) regs[i] = 16'h0100 + 16'(i);
        run_dump(1'b0);
        vec_cnt++; if (n_words !== 17) begin err_cnt++; $display("FAIL csum_count: got %0d want 17", n_words); end
        vec_cnt++; if (cap_last[15] !== 1'b0) begin err_cnt++; $display("FAIL csum_last15: got %b want 0", cap_last[15]); end
        vec_cnt++; if (cap_data[16] !== 16'h0000 || cap_last[16] !== 1'b1 || cap_idx[16] !== 4'd15) begin
            err_cnt++; $display("FAIL csum_seq: got %h last %b idx %0d want 0000/1/15", cap_data[16], cap_last[16], cap_idx[16]);
        end
        for (int i = 0; i < 16; i++) regs[i] = 16'hFFDD;
        run_dump(1'b0);
        vec_cnt++; if (cap_data[16] !== 16'h0000) begin err_cnt++; $display("FAIL csum_ffdd: got %h want 0000", cap_data[16]); end
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        regs[0] = 16'h1234;
        run_dump(1'b0);
        vec_cnt++; if (cap_data[16] !== 16'h1234) begin err_cnt++; $display("FAIL csum_1234: got %h want 1234", cap_data[16]); end
        $display("test_checksum: final word %h", cap_data[16]);
    endtask
`endif

    task automatic test_single_reg();
        int nw = 0, ndone = 0, nlast = 0;
        logic [15:0] d0 = '0;
        logic [3:0]  i0 = '0;
        regs[3] = 16'h5A3C;
        ready3 = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int c = 1; c < 12; c++) begin
            start3 = (c == 2);
            if (out_valid3 && ready3) begin
                if (nw == 0) begin d0 = out_data3; i0 = out_index3; end
                if (out_last3) nlast++;
                nw++;
            end
            if (done3) ndone++;
            @(negedge clk);
        end
        start3 = 1'b0;
        vec_cnt++; if (nw !== NW3) begin err_cnt++; $display("FAIL single_count: got %0d want %0d", nw, NW3); end
        vec_cnt++; if (d0 !== 16'h5A3C || i0 !== 4'd3) begin err_cnt++; $display("FAIL single_word: got %h@%0d want 5a3c@3", d0, i0); end
        vec_cnt++; if (nlast !== 1 || ndone !== 1) begin err_cnt++; $display("FAIL single_last_done: last %0d done %0d want 1/1", nlast, ndone); end
        vec_cnt++; if (busy3 !== 1'b0) begin err_cnt++; $display("FAIL single_idle: busy %b want 0", busy3); end
        $display("test_single_reg: %0d words", nw);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = '0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_abort();
        test_reset_mid_dump();
`ifdef REGDUMP_CHECKSUM_EN
        test_checksum();
`endif
        test_single_reg();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
